// File: rtl/con4_pkg.sv
// rtl/con4_pkg.sv - board geometry, cell codes, walk directions and index helpers
package con4_pkg;
  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;
  localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
  localparam logic [2:0] COL_LAST = 3'(COLS - 1);

  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D1, DIR_D2} dir_t;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  function automatic logic [5:0] cell_idx(logic [2:0] row, logic [2:0] col);
    return 6'(row) * 6'(COLS) + 6'(col);
  endfunction

  // Off-board coordinates read as EMPTY so callers never index past the board.
  function automatic logic [1:0] cell_at(logic [2*CELLS-1:0] board, logic [2:0] row, logic [2:0] col);
    if (row > ROW_LAST || col > COL_LAST) return EMPTY;
    return board[{cell_idx(row, col), 1'b0} +: 2];
  endfunction

  // A slot is {direction, half}; half 1 walks the negated delta.
  function automatic logic signed [4:0] slot_dr(logic [2:0] slot);
    logic signed [4:0] d;
    d = (dir_t'(slot[2:1]) == DIR_H) ? 5'sd0 : 5'sd1;
    return slot[0] ? -d : d;
  endfunction

  function automatic logic signed [4:0] slot_dc(logic [2:0] slot);
    logic signed [4:0] d;
    case (dir_t'(slot[2:1]))
      DIR_H, DIR_D1: d = 5'sd1;
      DIR_V:         d = 5'sd0;
      default:       d = -5'sd1;
    endcase
    return slot[0] ? -d : d;
  endfunction

  function automatic logic in_bounds(logic signed [4:0] row, logic signed [4:0] col);
    return (row >= 5'sd0) && (row <= $signed({2'b00, ROW_LAST})) &&
           (col >= 5'sd0) && (col <= $signed({2'b00, COL_LAST}));
  endfunction
endpackage

// File: rtl/con4_win_check_if.sv
// rtl/con4_win_check_if.sv - request/result bundle of the win checker
interface con4_win_check_if;
  import con4_pkg::*;

  logic                 start;
  logic [2*CELLS-1:0]   board;
  logic [2:0]           last_row;
  logic [2:0]           last_col;
  logic [1:0]           player;
  logic                 busy;
  logic                 done;
  logic                 win;
  logic                 draw;
  logic                 bad_req;

  modport master (output start, board, last_row, last_col, player,
                  input  busy, done, win, draw, bad_req);
  modport slave  (input  start, board, last_row, last_col, player,
                  output busy, done, win, draw, bad_req);
endinterface

// File: rtl/con4_step_gen.sv
// rtl/con4_step_gen.sv - picks the next in-bounds probe, skipping off-board half-walks
module con4_step_gen
  import con4_pkg::*;
(
  input  logic       first,
  input  logic       cont,
  input  logic [2:0] org_row,
  input  logic [2:0] org_col,
  input  logic [2:0] cur_row,
  input  logic [2:0] cur_col,
  input  dir_t       cur_dir,
  input  logic       cur_half,
  output logic       nxt_valid,
  output logic [2:0] nxt_row,
  output logic [2:0] nxt_col,
  output dir_t       nxt_dir,
  output logic       nxt_half,
  output logic       nxt_same,
  output logic       nxt_new_dir
);
  logic [2:0]        cur_slot;
  logic [2:0]        slot;
  logic signed [4:0] cr, cc;

  assign cur_slot = {cur_dir, cur_half};

  always_comb begin
    nxt_valid   = 1'b0;
    nxt_row     = 3'd0;
    nxt_col     = 3'd0;
    nxt_dir     = DIR_H;
    nxt_half    = 1'b0;
    nxt_same    = 1'b0;
    nxt_new_dir = 1'b0;
    slot        = 3'd0;
    cr          = 5'sd0;
    cc          = 5'sd0;
    if (!first && cont) begin
      cr = $signed({2'b00, cur_row}) + slot_dr(cur_slot);
      cc = $signed({2'b00, cur_col}) + slot_dc(cur_slot);
      if (in_bounds(cr, cc)) begin
        nxt_valid = 1'b1;
        nxt_row   = cr[2:0];
        nxt_col   = cc[2:0];
        nxt_dir   = cur_dir;
        nxt_half  = cur_half;
        nxt_same  = 1'b1;
      end
    end
    // Later half-walks whose first cell is off-board cost no cycle.
    for (int j = 0; j < 8; j++) begin
      slot = 3'(j);
      if (!nxt_valid && (first || slot > cur_slot)) begin
        cr = $signed({2'b00, org_row}) + slot_dr(slot);
        cc = $signed({2'b00, org_col}) + slot_dc(slot);
        if (in_bounds(cr, cc)) begin
          nxt_valid   = 1'b1;
          nxt_row     = cr[2:0];
          nxt_col     = cc[2:0];
          nxt_dir     = dir_t'(slot[2:1]);
          nxt_half    = slot[0];
          nxt_new_dir = first || (dir_t'(slot[2:1]) != cur_dir);
        end
      end
    end
  end
endmodule

// File: rtl/con4_win_check.sv
// rtl/con4_win_check.sv - connect-four win/draw checker walking outward from the last move
module con4_win_check
  import con4_pkg::*;
#(
  parameter int WIN_LEN = 4
) (
  input logic            clk,
  input logic            rst,
  con4_win_check_if.slave bus
);
  localparam logic [2:0] WIN_CNT  = 3'(WIN_LEN);
  localparam logic [2:0] HALF_MAX = 3'(WIN_LEN - 1);

  state_t             state, state_nx;
  logic [2*CELLS-1:0] board_q;
  logic [1:0]         player_q;
  logic [2:0]         org_row, org_col, cur_row, cur_col, steps, count;
  dir_t               dir_q;
  logic               half_q, win_q, draw_q, bad_q;

  logic               bad_in, match, hit_win, cont, full, draw_now;
  logic [2:0]         count_inc, sg_org_row, sg_org_col, sg_row, sg_col;
  logic               sg_valid, sg_half, sg_same, sg_new_dir;
  dir_t               sg_dir;

  always_comb begin
    bad_in = (bus.player != P1 && bus.player != P2) ||
             bus.last_row > ROW_LAST || bus.last_col > COL_LAST ||
             cell_at(bus.board, bus.last_row, bus.last_col) != bus.player;
    match      = (state == WALK) && (cell_at(board_q, cur_row, cur_col) == player_q);
    count_inc  = match ? count + 3'd1 : count;
    hit_win    = match && (count_inc == WIN_CNT);
    cont       = match && (steps + 3'd1 < HALF_MAX);
    sg_org_row = (state == IDLE) ? bus.last_row : org_row;
    sg_org_col = (state == IDLE) ? bus.last_col : org_col;
    full = 1'b1;
    for (int k = 0; k < CELLS; k++)
      if (board_q[2*k +: 2] == EMPTY) full = 1'b0;
    draw_now = (state == DONE) && !win_q && !bad_q && full;
  end

  con4_step_gen u_step (
    .first       (state == IDLE),
    .cont        (cont),
    .org_row     (sg_org_row),
    .org_col     (sg_org_col),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .cur_dir     (dir_q),
    .cur_half    (half_q),
    .nxt_valid   (sg_valid),
    .nxt_row     (sg_row),
    .nxt_col     (sg_col),
    .nxt_dir     (sg_dir),
    .nxt_half    (sg_half),
    .nxt_same    (sg_same),
    .nxt_new_dir (sg_new_dir)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bad_in || !sg_valid) ? DONE : WALK;
      WALK:    if (hit_win || !sg_valid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_q  <= '0;
      player_q <= 2'b00;
      org_row  <= 3'd0;
      org_col  <= 3'd0;
      cur_row  <= 3'd0;
      cur_col  <= 3'd0;
      steps    <= 3'd0;
      count    <= 3'd0;
      dir_q    <= DIR_H;
      half_q   <= 1'b0;
      win_q    <= 1'b0;
      draw_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          board_q  <= bus.board;
          player_q <= bus.player;
          org_row  <= bus.last_row;
          org_col  <= bus.last_col;
          cur_row  <= sg_row;
          cur_col  <= sg_col;
          dir_q    <= sg_dir;
          half_q   <= sg_half;
          steps    <= 3'd0;
          count    <= 3'd1;
          win_q    <= 1'b0;
          draw_q   <= 1'b0;
          bad_q    <= bad_in;
        end
        WALK: if (hit_win) begin
          win_q <= 1'b1;
        end else if (sg_valid) begin
          cur_row <= sg_row;
          cur_col <= sg_col;
          dir_q   <= sg_dir;
          half_q  <= sg_half;
          steps   <= sg_same ? steps + 3'd1 : 3'd0;
          count   <= sg_new_dir ? 3'd1 : count_inc;
        end
        DONE:    draw_q <= draw_now;
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == WALK);
  assign bus.done    = (state == DONE);
  assign bus.win     = win_q;
  assign bus.draw    = draw_q | draw_now;
  assign bus.bad_req = bad_q;
endmodule

// File: tb/tb_con4_win_check.sv
// tb/tb_con4_win_check.sv - table, random and sequence checks of con4_win_check
module tb_con4_win_check;
  import con4_pkg::*;
  localparam int WL = 4;

  typedef struct {
    logic [83:0] board;
    int lr, lc, pl, ewin, edraw, ebad, elat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_total = 0;
  int n_pass = 0;
  vec_t vecs[$];

  con4_win_check_if bus();
  con4_win_check #(.WIN_LEN(WL)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic logic [83:0] put(input logic [83:0] b, input int r, input int c, input int v);
    b[2*(r*7+c) +: 2] = 2'(v);
    return b;
  endfunction

  function automatic int get(input logic [83:0] b, input int r, input int c);
    return int'(b[2*(r*7+c) +: 2]);
  endfunction

  function automatic vec_t mk(input logic [83:0] b, input int lr, input int lc, input int pl,
                              input int ew, input int ed, input int eb, input int el);
    vec_t v;
    v.board = b; v.lr = lr; v.lc = lc; v.pl = pl;
    v.ewin = ew; v.edraw = ed; v.ebad = eb; v.elat = el;
    return v;
  endfunction

  // Reference: walk each line outward counting same-player cells, one cycle per on-board probe.
  function automatic vec_t model(input logic [83:0] b, input int lr, input int lc, input int pl);
    int dr[4];
    int dc[4];
    int probes, cnt, filled, r, c, sg, ew;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    if (!(pl == 1 || pl == 2) || lr > 5 || lc > 6 || get(b, lr, lc) != pl)
      return mk(b, lr, lc, pl, 0, 0, 1, 1);
    probes = 0;
    ew = 0;
    for (int d = 0; d < 4 && ew == 0; d++) begin
      cnt = 1;
      for (int s = 0; s < 2 && ew == 0; s++) begin
        sg = (s == 0) ? 1 : -1;
        for (int k = 1; k < WL; k++) begin
          r = lr + sg * k * dr[d];
          c = lc + sg * k * dc[d];
          if (r < 0 || r > 5 || c < 0 || c > 6) break;
          probes++;
          if (get(b, r, c) != pl) break;
          cnt++;
          if (cnt >= WL) begin ew = 1; break; end
        end
      end
    end
    filled = 0;
    for (int k = 0; k < 42; k++) if (b[2*k +: 2] != 2'b00) filled++;
    return mk(b, lr, lc, pl, ew, (ew == 0 && filled == 42) ? 1 : 0, 0, probes + 1);
  endfunction

  task automatic drive(input vec_t v);
    bus.board    = v.board;
    bus.last_row = 3'(v.lr);
    bus.last_col = 3'(v.lc);
    bus.player   = 2'(v.pl);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    drive(v);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.board  = ~v.board;
    bus.player = 2'(v.pl) ^ 2'b11;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1 && v.elat > 1) check({tag, ".busy"}, int'(bus.busy), 1);
      if (bus.done) begin lat = cyc; break; end
      @(posedge clk); #1;
    end
    check({tag, ".lat"}, lat, v.elat);
    check({tag, ".win"}, int'(bus.win), v.ewin);
    check({tag, ".draw"}, int'(bus.draw), v.edraw);
    check({tag, ".bad"}, int'(bus.bad_req), v.ebad);
    @(posedge clk); #1;
    check({tag, ".pulse"}, int'(bus.done), 0);
    check({tag, ".hold_win"}, int'(bus.win), v.ewin);
    check({tag, ".hold_draw"}, int'(bus.draw), v.edraw);
  endtask

  initial begin
    logic [83:0] b;
    logic [83:0] db;
    vec_t v;
    int dones, seen;

    bus.start = 1'b0; bus.board = '0; bus.last_row = 3'd0; bus.last_col = 3'd0; bus.player = 2'b00;
    #2;
    check("reset.busy", int'(bus.busy), 0);
    check("reset.done", int'(bus.done), 0);
    check("reset.win", int'(bus.win), 0);
    check("reset.draw", int'(bus.draw), 0);
    check("reset.bad", int'(bus.bad_req), 0);
    @(negedge clk);
    rst = 1'b1;

    db = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        db = put(db, r, c, ((((r >> 1) & 1) ^ (c & 1)) != 0) ? 2 : 1);

    b = put('0, 0, 0, 1);
    vecs.push_back(mk(b, 0, 0, 1, 0, 0, 0, 4));
    vecs.push_back(mk(b, 0, 0, 3, 0, 0, 1, 1));
    vecs.push_back(mk(b, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(b, 0, 0, 2, 0, 0, 1, 1));
    b = '0;
    for (int c = 0; c < 4; c++) b = put(b, 0, c, 1);
    vecs.push_back(mk(b, 0, 3, 1, 1, 0, 0, 5));
    b = put(put(put(put('0, 0, 3, 2), 1, 2, 2), 2, 1, 2), 3, 0, 2);
    vecs.push_back(mk(b, 3, 0, 2, 1, 0, 0, 8));
    b = '0;
    for (int r = 0; r < 4; r++) b = put(b, r, 2, 1);
    vecs.push_back(mk(b, 3, 2, 1, 1, 0, 0, 7));
    b = put(put(put('0, 0, 0, 1), 0, 1, 1), 0, 2, 1);
    vecs.push_back(mk(b, 0, 1, 1, 0, 0, 0, 7));
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, k, k, 1);
    vecs.push_back(mk(b, 1, 1, 1, 1, 0, 0, 9));
    vecs.push_back(mk(db, 5, 6, 1, 0, 1, 0, 5));
    vecs.push_back(mk(db, 5, 6, 2, 0, 0, 1, 1));
    vecs.push_back(mk('0, 6, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk('0, 0, 7, 1, 0, 0, 1, 1));

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    for (int it = 0; it < 160; it++) begin
      int mode, lr, lc, pl;
      logic [83:0] rb;
      mode = int'($urandom_range(0, 9));
      rb = '0;
      for (int k = 0; k < 42; k++)
        rb[2*k +: 2] = 2'((mode >= 7) ? $urandom_range(1, 2) : $urandom_range(0, 2));
      if (mode == 0) begin
        pl = int'($urandom_range(0, 3));
        lr = int'($urandom_range(0, 7));
        lc = int'($urandom_range(0, 7));
      end else begin
        pl = int'($urandom_range(1, 2));
        lr = int'($urandom_range(0, 5));
        lc = int'($urandom_range(0, 6));
        rb = put(rb, lr, lc, pl);
      end
      run_vec($sformatf("rand%0d", it), model(rb, lr, lc, pl));
    end

    // start during WALK is dropped
    @(negedge clk);
    drive(vecs[0]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.player = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    check("busy_start.dones", dones, 1);
    check("busy_start.bad", int'(bus.bad_req), 0);

    // start during DONE is dropped
    @(negedge clk);
    drive(vecs[0]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check("done_start.seen", seen, 1);
    drive(vecs[4]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    check("done_start.dones", dones, 0);
    check("done_start.win", int'(bus.win), 0);

    // reset in cycle 3 of a walk
    run_vec("pre_reset", vecs[4]);
    @(negedge clk);
    drive(vecs[0]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_walk.busy", int'(bus.busy), 0);
    check("rst_walk.done", int'(bus.done), 0);
    check("rst_walk.win", int'(bus.win), 0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("rst_walk.dones", dones, 0);
    @(negedge clk);
    rst = 1'b1;
    run_vec("post_reset", vecs[5]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
